// File: rtl/gpi_poll_ctrl.sv
// APB master that configures the GPI peripheral, polls its IDR and latches per-bit edge events.
// state      | meaning
// IDLE       | bus quiet, waiting for en
// CFG_SETUP  | CR write setup phase (PWDATA = cfg_mask)
// CFG_ACCESS | CR write access phase
// WAIT       | poll-interval down-counter running
// RD_SETUP   | IDR read setup phase
// RD_ACCESS  | IDR read access phase, capture on PREADY
// DIS_SETUP  | CR write setup phase (PWDATA = 0)
// DIS_ACCESS | CR write access phase, then IDLE
module gpi_poll_ctrl #(
  parameter int         POLL_DIV = 1000,
  parameter int         TIMEOUT  = 16,
  parameter logic [3:0] CR_ADDR  = 4'h0,
  parameter logic [3:0] IDR_ADDR = 4'h4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic [3:0]  PADDR,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  output logic        PSEL,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        en,
  input  logic [7:0]  mask,
  input  logic [7:0]  rise_en,
  input  logic [7:0]  fall_en,
  input  logic [7:0]  pend_clr,
  input  logic        err_clr,
  output logic [7:0]  gpi_state,
  output logic [7:0]  pend,
  output logic        irq,
  output logic        busy,
  output logic        err
);

  localparam int WW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_SETUP, S_CFG_ACCESS, S_WAIT,
    S_RD_SETUP, S_RD_ACCESS, S_DIS_SETUP, S_DIS_ACCESS
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    cfg_mask;
  logic          prime;
  logic          relatch, capture, timeout;
  logic [7:0]    sample, ev_set;
  logic          unused_prdata;

  assign unused_prdata = ^PRDATA[31:8];
  assign sample = PRDATA[7:0] & cfg_mask;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    relatch   = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_CFG_SETUP;
          relatch   = 1'b1;
        end
      end
      S_CFG_SETUP: state_nxt = S_CFG_ACCESS;
      S_CFG_ACCESS: begin
        if (PREADY) begin
          state_nxt = en ? S_WAIT : S_DIS_SETUP;
        end else if (to_cnt == '0) begin
          timeout   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!en) begin
          state_nxt = S_DIS_SETUP;
        end else if (mask != cfg_mask) begin
          state_nxt = S_CFG_SETUP;
          relatch   = 1'b1;
        end else if (wait_cnt == '0) begin
          state_nxt = S_RD_SETUP;
        end
      end
      S_RD_SETUP: state_nxt = S_RD_ACCESS;
      S_RD_ACCESS: begin
        if (PREADY) begin
          capture   = 1'b1;
          state_nxt = en ? S_WAIT : S_DIS_SETUP;
        end else if (to_cnt == '0) begin
          timeout   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_DIS_SETUP: state_nxt = S_DIS_ACCESS;
      S_DIS_ACCESS: begin
        if (PREADY) begin
          state_nxt = S_IDLE;
        end else if (to_cnt == '0) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus signals decode straight from state so a reset drops PSEL/PENABLE immediately.
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 4'h0;
    PWDATA  = 32'h0;
    case (state)
      S_CFG_SETUP, S_CFG_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state == S_CFG_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = CR_ADDR;
        PWDATA  = {24'h0, cfg_mask};
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state == S_RD_ACCESS);
        PADDR   = IDR_ADDR;
      end
      S_DIS_SETUP, S_DIS_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state == S_DIS_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = CR_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (state_nxt == S_WAIT && state != S_WAIT) wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;

      if (state == S_CFG_SETUP || state == S_RD_SETUP || state == S_DIS_SETUP)
        to_cnt <= TO_LOAD;
      else if (PENABLE && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
    end
  end

  // The first capture after a (re)configuration only seeds the image.
  always_comb begin
    ev_set = 8'h0;
    if (capture && !prime)
      ev_set = (sample & ~gpi_state & rise_en) | (~sample & gpi_state & fall_en);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cfg_mask  <= 8'h0;
      prime     <= 1'b0;
      gpi_state <= 8'h0;
      pend      <= 8'h0;
      err       <= 1'b0;
    end else begin
      if (relatch) begin
        cfg_mask <= mask;
        prime    <= 1'b1;
      end else if (capture) begin
        prime <= 1'b0;
      end
      if (capture) gpi_state <= sample;
      pend <= (pend & ~pend_clr) | ev_set;
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign irq  = |pend;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_gpi_poll_ctrl.sv
// Directed bench for gpi_poll_ctrl: APB slave model, table-driven edge vectors, corner sequences.
module tb_gpi_poll_ctrl;
  localparam int P = 10;
  localparam int T = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic        PWRITE, PENABLE, PSEL;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY = 1'b0;
  logic        en, err_clr;
  logic [7:0]  mask, rise_en, fall_en, pend_clr;
  logic [7:0]  gpi_state, pend;
  logic        irq, busy, err;
  logic [7:0]  gpi_in;

  int n_chk = 0;
  int n_err = 0;

  int          acc_cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  wr_addr = 4'h0;
  logic [31:0] wr_data = 32'h0;
  bit          slv_stuck = 1'b0;

  gpi_poll_ctrl #(.POLL_DIV(P), .TIMEOUT(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .en(en), .mask(mask),
    .rise_en(rise_en), .fall_en(fall_en), .pend_clr(pend_clr), .err_clr(err_clr),
    .gpi_state(gpi_state), .pend(pend), .irq(irq), .busy(busy), .err(err)
  );

  always #5 PCLK = ~PCLK;

  assign PRDATA = {24'hA5A5A5, gpi_in};

  // Slave: one wait state in ACCESS, then PREADY; logs completed transfers.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_cyc = acc_cyc + 1;
    else                 acc_cyc = 0;
    PREADY = PSEL && PENABLE && (acc_cyc >= 2) && !slv_stuck;
    if (PREADY) begin
      if (PWRITE) begin
        wr_cnt  = wr_cnt + 1;
        wr_addr = PADDR;
        wr_data = PWDATA;
      end else begin
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [7:0] gpi, ren, fen, clr, exp_state, exp_pend;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired, got no event, required event", name);
  endtask

  task automatic wait_rd(input string name);
    int  start;
    bit  done;
    start = rd_cnt;
    done  = 1'b0;
    for (int i = 0; i < 4 * P + 100 && !done; i++) begin
      @(posedge PCLK);
      if (rd_cnt != start) done = 1'b1;
    end
    if (!done) bound_fail(name);
    @(negedge PCLK);
  endtask

  task automatic wait_wr(input string name);
    int  start;
    bit  done;
    start = wr_cnt;
    done  = 1'b0;
    for (int i = 0; i < 4 * P + 100 && !done; i++) begin
      @(posedge PCLK);
      if (wr_cnt != start) done = 1'b1;
    end
    if (!done) bound_fail(name);
    @(negedge PCLK);
  endtask

  task automatic wait_rd_phase(input bit acc, input string name);
    int i;
    i = 0;
    while (!(PSEL && !PWRITE && PENABLE == acc) && i < 1000) begin
      @(negedge PCLK);
      i++;
    end
    if (i >= 1000) bound_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, gap, rdc;
    vt[0] = '{8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h08};
    vt[1] = '{8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2] = '{8'h81, 8'hFF, 8'h00, 8'hFF, 8'h81, 8'h81};
    vt[3] = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h80};
    vt[4] = '{8'h03, 8'h02, 8'h00, 8'hFF, 8'h03, 8'h82};
    vt[5] = '{8'hF0, 8'h00, 8'h03, 8'h01, 8'hF0, 8'h03};
    vt[6] = '{8'hF0, 8'hFF, 8'hFF, 8'h02, 8'hF0, 8'h02};

    PRESET = 1'b1; en = 1'b0; mask = 8'h00; rise_en = 8'h00; fall_en = 8'h00;
    pend_clr = 8'h00; err_clr = 1'b0; gpi_in = 8'h00;
    repeat (2) @(negedge PCLK);
    chk("reset_outs", {PSEL, PENABLE, PWRITE, busy, irq, err, PADDR, gpi_state, pend}, 64'h0);
    chk("reset_pwdata", PWDATA, 64'h0);

    // Start-up: CR write then first IDR read after P idle cycles
    PRESET = 1'b0; mask = 8'hFF; en = 1'b1;
    @(negedge PCLK);
    chk("cfg_setup", {PSEL, PENABLE, PWRITE, busy, PADDR}, {1'b1, 1'b0, 1'b1, 1'b1, 4'h0});
    chk("cfg_pwdata", PWDATA, 64'hFF);
    @(negedge PCLK);
    acc = 0;
    while (PSEL && PENABLE && acc < 100) begin
      acc++;
      @(negedge PCLK);
    end
    chk("cfg_access_len", acc, 2);
    chk("cfg_wr", {wr_addr, wr_data}, {4'h0, 32'hFF});
    gap = 0;
    while (!PSEL && gap < 5000) begin
      gap++;
      @(negedge PCLK);
    end
    chk("first_rd_gap", gap, P);
    chk("rd_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b0, 4'h4});
    wait_rd("prime_rd");
    chk("prime_pend", {pend, irq}, 9'h0);
    chk("prime_state", gpi_state, 64'h0);

    for (int i = 0; i < 7; i++) begin
      gpi_in = vt[i].gpi; rise_en = vt[i].ren; fall_en = vt[i].fen;
      wait_rd($sformatf("vec%0d_rd", i));
      chk($sformatf("vec%0d_state", i), gpi_state, vt[i].exp_state);
      chk($sformatf("vec%0d_pend", i), {pend, irq}, {vt[i].exp_pend, |vt[i].exp_pend});
      pend_clr = vt[i].clr;
      @(negedge PCLK);
      pend_clr = 8'h00;
      chk($sformatf("vec%0d_clr", i), pend, vt[i].exp_pend & ~vt[i].clr);
    end

    // Mask narrowing/widening: masked bits ignored, reconfig primes without events
    mask = 8'h0F; gpi_in = 8'h80; rise_en = 8'hFF; fall_en = 8'hFF;
    wait_wr("mask0f_wr");
    chk("mask0f_wr", {wr_addr, wr_data}, {4'h0, 32'h0F});
    wait_rd("mask0f_rd1");
    chk("mask0f_rd1", {gpi_state, pend}, 16'h0);
    gpi_in = 8'h00;
    wait_rd("mask0f_rd2");
    chk("mask0f_rd2", {gpi_state, pend}, 16'h0);
    gpi_in = 8'h30;
    wait_rd("mask0f_rd3");
    chk("mask0f_rd3", {gpi_state, pend}, 16'h0);
    mask = 8'h3F;
    wait_wr("mask3f_wr");
    chk("mask3f_wr", wr_data, 64'h3F);
    wait_rd("mask3f_rd");
    chk("mask3f_state", gpi_state, 64'h30);
    chk("mask3f_no_event", {pend, irq}, 9'h0);

    // Set beats pend_clr on the capture cycle
    rise_en = 8'h01; fall_en = 8'h00; gpi_in = 8'h31; pend_clr = 8'h01;
    wait_rd("set_wins_rd");
    chk("set_wins", {pend, irq}, {8'h01, 1'b1});
    pend_clr = 8'h00;
    @(negedge PCLK);
    chk("set_wins_hold", pend, 64'h01);
    pend_clr = 8'h01;
    @(negedge PCLK);
    pend_clr = 8'h00;
    chk("set_wins_clr", {pend, irq}, 9'h0);

    // PREADY stuck during a read: abort after T ACCESS cycles
    gpi_in = 8'h3F; slv_stuck = 1'b1;
    wait_rd_phase(1'b0, "to_rd_setup");
    @(negedge PCLK);
    acc = 0;
    while (PSEL && PENABLE && acc < 100) begin
      acc++;
      @(negedge PCLK);
    end
    chk("timeout_len", acc, T);
    chk("timeout_err", {PSEL, err}, 2'b01);
    chk("timeout_no_capture", gpi_state, 64'h31);
    slv_stuck = 1'b0;
    gap = 0;
    while (!PSEL && gap < 5000) begin
      gap++;
      @(negedge PCLK);
    end
    chk("post_to_gap", gap, P);
    chk("err_sticky", err, 1'b1);
    wait_rd("post_to_rd");
    chk("post_to_state", {gpi_state, pend}, {8'h3F, 8'h00});
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    chk("err_clr", err, 1'b0);

    // en dropped mid-read: read finishes, then CR disable write, then idle
    wait_rd_phase(1'b1, "dis_rd_access");
    en = 1'b0;
    rdc = rd_cnt;
    wait_wr("dis_wr");
    chk("dis_rd_done", rd_cnt, rdc + 1);
    chk("dis_wr", {wr_addr, wr_data}, {4'h0, 32'h0});
    chk("dis_idle", {busy, PSEL}, 2'b00);

    // Reset in the middle of an ACCESS phase
    en = 1'b1; gpi_in = 8'h00;
    wait_wr("re_cfg_wr");
    wait_rd("re_prime_rd");
    gpi_in = 8'h01;
    wait_rd("pre_rst_rd");
    chk("pre_rst_pend", pend, 64'h01);
    slv_stuck = 1'b1;
    wait_rd_phase(1'b1, "rst_rd_access");
    PRESET = 1'b1;
    #1;
    chk("rst_mid_access", {PSEL, PENABLE, busy, irq, pend}, 12'h0);
    @(negedge PCLK);
    PRESET = 1'b0; slv_stuck = 1'b0; en = 1'b0;
    @(negedge PCLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
